popcount_vec_gen: RTL



---
 rtl/popcount_pkg.sv | 18 +
 rtl/popcount_vec_gen_if.sv | 27 ++
 rtl/popgen_offset_ctr.sv | 29 ++
 rtl/popcount_vec_gen.sv | 99 +++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared constants, vector/count types and generator state encoding for the
// popcount stimulus generator family.
package popcount_pkg;

  localparam int POPCNT_N    = 29;
  localparam int POPCNT_CW   = 5;
  localparam int POPGEN_STEP = 7;

  typedef logic [POPCNT_N-1:0]  popcnt_vec_t;
  typedef logic [POPCNT_CW-1:0] popcnt_cnt_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } popgen_state_e;

endpackage

// File: rtl/popcount_vec_gen_if.sv
// Request/vector handshake bundle for popcount_vec_gen. Both channels are
// valid/ready: a transfer happens on a rising edge where valid and ready are both
// high. The sender keeps valid and its payload steady until that edge, and ready
// never depends on valid.
interface popcount_vec_gen_if #(
  parameter int N  = 29,
  parameter int CW = 5
);
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_count;
  logic          vec_valid;
  logic          vec_ready;
  logic [N-1:0]  vec_data;
  logic [CW-1:0] vec_count;
  logic          vec_sat;

  modport gen (
    input  req_valid, req_count, vec_ready,
    output req_ready, vec_valid, vec_data, vec_count, vec_sat
  );

  modport host (
    output req_valid, req_count, vec_ready,
    input  req_ready, vec_valid, vec_data, vec_count, vec_sat
  );
endinterface

// File: rtl/popgen_offset_ctr.sv
// Modulo-N start-offset accumulator: adds STEP on each advance pulse, wrapping
// with one conditional subtract (offset + STEP is always below 2N).
module popgen_offset_ctr #(
  parameter int N    = 29,
  parameter int CW   = 5,
  parameter int STEP = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  output logic [CW-1:0] offset
);

  localparam logic [CW:0] N_W    = (CW+1)'(N);
  localparam logic [CW:0] STEP_W = (CW+1)'(STEP);

  logic [CW:0] sum;

  assign sum = {1'b0, offset} + STEP_W;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset <= '0;
    end else if (adv) begin
      offset <= (sum >= N_W) ? CW'(sum - N_W) : sum[CW-1:0];
    end
  end

endmodule

// File: rtl/popcount_vec_gen.sv
// Emits an N-bit vector holding exactly min(req_count, N) ones, placed one bit per
// cycle from a start offset. Define POPGEN_ROTATE_EN to rotate that offset per vector.
module popcount_vec_gen
  import popcount_pkg::*;
#(
  parameter int N    = POPCNT_N,
  parameter int CW   = POPCNT_CW,
  parameter int STEP = POPGEN_STEP
) (
  input  logic               clk,
  input  logic               rst_n,
  popcount_vec_gen_if.gen    bus,
  output popgen_state_e      state_dbg
);

  localparam logic [CW-1:0] N_C  = CW'(N);
  localparam logic [CW-1:0] N_M1 = CW'(N - 1);

  popgen_state_e state, state_nxt;
  logic [N-1:0]  shadow;
  logic [CW-1:0] k_q, pos, remaining, idx, offset, k_in;
  logic          sat_q, sat_in, req_acc, vec_acc;

  assign req_acc = bus.req_valid && (state == IDLE);
  assign vec_acc = bus.vec_ready && (state == HOLD);
  assign sat_in  = (bus.req_count > N_C);
  assign k_in    = sat_in ? N_C : bus.req_count;

`ifdef POPGEN_ROTATE_EN
  popgen_offset_ctr #(.N(N), .CW(CW), .STEP(STEP)) u_offset (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv    (vec_acc),
    .offset (offset)
  );
`else
  logic [CW-1:0] unused_step;
  assign unused_step = CW'(STEP);
  assign offset      = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_acc) state_nxt = FILL;
      FILL:    if (idx == N_M1) state_nxt = HOLD;
      HOLD:    if (vec_acc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every FILL cycle writes one position, so the run length is N whatever k is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      k_q       <= '0;
      sat_q     <= 1'b0;
      pos       <= '0;
      remaining <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_acc) begin
            shadow    <= '0;
            k_q       <= k_in;
            sat_q     <= sat_in;
            remaining <= k_in;
            pos       <= offset;
            idx       <= '0;
          end
        end
        FILL: begin
          shadow[pos] <= (remaining != '0);
          if (remaining != '0) remaining <= remaining - 1'b1;
          pos <= (pos == N_M1) ? '0 : pos + 1'b1;
          idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.vec_valid = (state == HOLD);
  assign bus.vec_data  = shadow;
  assign bus.vec_count = k_q;
  assign bus.vec_sat   = sat_q;
  assign state_dbg     = state;

endmodule
